// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared state encoding, defaults and window modes for the systolic array sequencer
package sa_pkg;

    localparam int SA_N     = 4;
    localparam int SA_CNT_W = 16;
    localparam int DATA_W   = 16;

    typedef enum logic [2:0] {
        IDLE,
        WLOAD,
        STREAM,
        FLUSH,
        DONE
    } sa_state_t;

    // Window generator modes: rows open at s = r, columns open at s = N + c
    localparam logic WIN_ROW = 1'b0;
    localparam logic WIN_COL = 1'b1;

endpackage

// File: rtl/sa_window_gen.sv
// rtl/sa_window_gen.sv - combinational per-lane skew window decoder for rows or columns
module sa_window_gen
    import sa_pkg::*;
#(
    parameter int N     = SA_N,
    parameter int CNT_W = SA_CNT_W
) (
    input  logic [CNT_W:0]   s,
    input  logic [CNT_W-1:0] m,
    input  logic             mode,
    output logic [N-1:0]     win
);

    localparam int EXT_W = CNT_W + 2;

    // Lane i is live for m cycles from offset+i; the half-open upper bound keeps m = 0 empty
    always_comb begin
        logic [EXT_W-1:0] lo;
        lo  = '0;
        win = '0;
        for (int i = 0; i < N; i++) begin
            lo     = EXT_W'(i) + ((mode == WIN_COL) ? EXT_W'(N) : EXT_W'(0));
            win[i] = ({1'b0, s} >= lo) && ({1'b0, s} < (lo + {2'b00, m}));
        end
    end

endmodule

// File: rtl/sa_ctrl.sv
// rtl/sa_ctrl.sv - weight-stationary systolic array job sequencer; SA_CTRL_PERF_EN adds busy-cycle and job counters
module sa_ctrl
    import sa_pkg::*;
#(
    parameter int N     = SA_N,
    parameter int CNT_W = SA_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 cfg_load_w,
    input  logic [CNT_W-1:0]     cfg_m,
    output logic                 busy,
    output logic                 done,
    output logic [$clog2(N)-1:0] wt_rd_addr,
    output logic [N-1:0]         weight_en,
    output logic [CNT_W-1:0]     act_rd_addr,
    output logic                 act_rd_en,
    output logic [N-1:0]         row_valid,
    output logic                 compute,
    output logic [N-1:0]         col_valid
`ifdef SA_CTRL_PERF_EN
    ,
    output logic [31:0]          perf_busy_cycles,
    output logic [15:0]          perf_jobs
`endif
);

    localparam int AW = $clog2(N);
    localparam int TW = CNT_W + 1;

    sa_state_t        state;
    logic [AW-1:0]    w_q;
    logic [TW-1:0]    t_q;
    logic [CNT_W-1:0] m_q;

    logic [CNT_W-1:0] m_nx;
    logic [TW-1:0]    t_nx;
    logic [TW-1:0]    s_nx;
    logic [TW-1:0]    last_t;
    logic [TW-1:0]    rd_end;
    logic             stream_nx;
    logic             flush_nx;
    logic             rd_nx;
    logic [N-1:0]     row_win;
    logic [N-1:0]     col_win;

    // Look ahead one cycle so every array-facing strobe can be driven from a register
    always_comb begin
        m_nx      = (state == IDLE) ? cfg_m : m_q;
        last_t    = {1'b0, m_q} + TW'(2 * N - 3);
        rd_end    = {1'b0, m_nx} + TW'(N - 1);
        stream_nx = 1'b0;
        flush_nx  = 1'b0;
        t_nx      = '0;
        case (state)
            IDLE:    stream_nx = start && !cfg_load_w && (cfg_m != '0);
            WLOAD:   stream_nx = (w_q == AW'(N - 1)) && (m_q != '0);
            STREAM: begin
                if (t_q == last_t) begin
                    flush_nx = 1'b1;
                end else begin
                    stream_nx = 1'b1;
                    t_nx      = t_q + 1'b1;
                end
            end
            default: ;
        endcase
        s_nx  = flush_nx ? ({1'b0, m_q} + TW'(2 * N - 2)) : t_nx;
        rd_nx = stream_nx && (t_nx < rd_end);
    end

    sa_window_gen #(.N(N), .CNT_W(CNT_W)) u_row_win (
        .s    (s_nx),
        .m    (m_nx),
        .mode (WIN_ROW),
        .win  (row_win)
    );

    sa_window_gen #(.N(N), .CNT_W(CNT_W)) u_col_win (
        .s    (s_nx),
        .m    (m_nx),
        .mode (WIN_COL),
        .win  (col_win)
    );

    // Job FSM with registered strobes; a reset mid-job drops straight to IDLE without done
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            w_q         <= '0;
            t_q         <= '0;
            m_q         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            wt_rd_addr  <= '0;
            weight_en   <= '0;
            act_rd_addr <= '0;
            act_rd_en   <= 1'b0;
            row_valid   <= '0;
            compute     <= 1'b0;
            col_valid   <= '0;
        end else begin
            done        <= 1'b0;
            weight_en   <= '0;
            wt_rd_addr  <= '0;
            t_q         <= t_nx;
            compute     <= stream_nx;
            act_rd_en   <= rd_nx;
            act_rd_addr <= rd_nx ? t_nx[CNT_W-1:0] : '0;
            row_valid   <= stream_nx ? row_win : '0;
            col_valid   <= (stream_nx || flush_nx) ? col_win : '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        m_q  <= cfg_m;
                        w_q  <= '0;
                        busy <= 1'b1;
                        if (cfg_load_w) begin
                            state     <= WLOAD;
                            weight_en <= N'(1);
                        end else if (cfg_m == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= STREAM;
                        end
                    end
                end
                WLOAD: begin
                    if (w_q == AW'(N - 1)) begin
                        if (m_q == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= STREAM;
                        end
                    end else begin
                        w_q        <= w_q + 1'b1;
                        wt_rd_addr <= w_q + 1'b1;
                        weight_en  <= N'(1) << (w_q + 1'b1);
                    end
                end
                STREAM: begin
                    if (flush_nx) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SA_CTRL_PERF_EN
    // Busy-cycle counter saturates; job counter wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_busy_cycles <= '0;
            perf_jobs        <= '0;
        end else begin
            if (busy && (perf_busy_cycles != '1)) begin
                perf_busy_cycles <= perf_busy_cycles + 1'b1;
            end
            if (done) begin
                perf_jobs <= perf_jobs + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sa_ctrl.sv
// tb/tb_sa_ctrl.sv - scoreboard bench for sa_ctrl with hand-computed per-cycle expectations
module tb_sa_ctrl;

    localparam int N     = 4;
    localparam int CNT_W = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        cfg_load_w = 1'b0;
    logic [15:0] cfg_m = '0;
    logic        busy;
    logic        done;
    logic [1:0]  wt_rd_addr;
    logic [3:0]  weight_en;
    logic [15:0] act_rd_addr;
    logic        act_rd_en;
    logic [3:0]  row_valid;
    logic        compute;
    logic [3:0]  col_valid;
`ifdef SA_CTRL_PERF_EN
    logic [31:0] perf_busy_cycles;
    logic [15:0] perf_jobs;
`endif

    sa_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cfg_load_w  (cfg_load_w),
        .cfg_m       (cfg_m),
        .busy        (busy),
        .done        (done),
        .wt_rd_addr  (wt_rd_addr),
        .weight_en   (weight_en),
        .act_rd_addr (act_rd_addr),
        .act_rd_en   (act_rd_en),
        .row_valid   (row_valid),
        .compute     (compute),
        .col_valid   (col_valid)
`ifdef SA_CTRL_PERF_EN
        ,
        .perf_busy_cycles (perf_busy_cycles),
        .perf_jobs        (perf_jobs)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        bz;
        logic [3:0]  we;
        logic [1:0]  wa;
        logic        cmp;
        logic [3:0]  rv;
        logic [3:0]  cv;
        logic        ae;
        logic [15:0] aa;
        logic        dn;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_seen   = 0;

    task automatic push(input logic [3:0] we, input logic [1:0] wa, input logic cmp,
                        input logic [3:0] rv, input logic [3:0] cv, input logic ae,
                        input logic [15:0] aa, input logic dn);
        exp_t e;
        e = '{bz: 1'b1, we: we, wa: wa, cmp: cmp, rv: rv, cv: cv, ae: ae, aa: aa, dn: dn};
        exp_q.push_back(e);
    endtask

    task automatic push_wload();
        push(4'b0001, 2'd0, 1'b0, 4'b0000, 4'b0000, 1'b0, 16'd0, 1'b0);
        push(4'b0010, 2'd1, 1'b0, 4'b0000, 4'b0000, 1'b0, 16'd0, 1'b0);
        push(4'b0100, 2'd2, 1'b0, 4'b0000, 4'b0000, 1'b0, 16'd0, 1'b0);
        push(4'b1000, 2'd3, 1'b0, 4'b0000, 4'b0000, 1'b0, 16'd0, 1'b0);
    endtask

    task automatic push_s(input logic [3:0] rv, input logic [3:0] cv, input logic ae, input logic [15:0] aa);
        push(4'b0000, 2'd0, 1'b1, rv, cv, ae, aa, 1'b0);
    endtask

    task automatic push_flush(input logic [3:0] cv);
        push(4'b0000, 2'd0, 1'b0, 4'b0000, cv, 1'b0, 16'd0, 1'b0);
    endtask

    task automatic push_done();
        push(4'b0000, 2'd0, 1'b0, 4'b0000, 4'b0000, 1'b0, 16'd0, 1'b1);
    endtask

    // Monitor: every cycle with any activity must match the head of the expectation queue
    always @(negedge clk) begin
        exp_t got;
        exp_t e;
        got = '{bz: busy, we: weight_en, wa: wt_rd_addr, cmp: compute, rv: row_valid,
                cv: col_valid, ae: act_rd_en, aa: act_rd_addr, dn: done};
        if (busy === 1'b1 || done === 1'b1 || compute === 1'b1 || act_rd_en === 1'b1 ||
            weight_en !== 4'b0 || row_valid !== 4'b0 || col_valid !== 4'b0) begin
            n_checks++;
            n_seen++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_activity cycle=%0d got=%h want=idle", n_seen, got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard cycle=%0d got=%h want=%h", n_seen, got, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic issue(input logic lw, input logic [15:0] m);
        @(posedge clk); #1;
        start = 1'b1; cfg_load_w = lw; cfg_m = m;
        @(posedge clk); #1;
        start = 1'b0; cfg_load_w = 1'b0; cfg_m = '0;
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout pending=%0d want=0", tag, exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({busy, done, wt_rd_addr, weight_en, act_rd_addr, act_rd_en, row_valid, compute, col_valid});
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", all_outs(), 64'd0);
`ifdef SA_CTRL_PERF_EN
        check("reset_perf_busy", 64'(perf_busy_cycles), 64'd0);
        check("reset_perf_jobs", 64'(perf_jobs), 64'd0);
`endif
        rst = 1'b0;

        // Job A: load weights, m=3
        push_wload();
        push_s(4'b0001, 4'b0000, 1'b1, 16'd0);
        push_s(4'b0011, 4'b0000, 1'b1, 16'd1);
        push_s(4'b0111, 4'b0000, 1'b1, 16'd2);
        push_s(4'b1110, 4'b0000, 1'b1, 16'd3);
        push_s(4'b1100, 4'b0001, 1'b1, 16'd4);
        push_s(4'b1000, 4'b0011, 1'b1, 16'd5);
        push_s(4'b0000, 4'b0111, 1'b0, 16'd0);
        push_s(4'b0000, 4'b1110, 1'b0, 16'd0);
        push_s(4'b0000, 4'b1100, 1'b0, 16'd0);
        push_flush(4'b1000);
        push_done();
        issue(1'b1, 16'd3);
        drain("job_a");
`ifdef SA_CTRL_PERF_EN
        check("perf_busy_after_a", 64'(perf_busy_cycles), 64'd15);
        check("perf_jobs_after_a", 64'(perf_jobs), 64'd1);
`endif

        // Job B: resident weights, m=1, stray start during STREAM
        push_s(4'b0001, 4'b0000, 1'b1, 16'd0);
        push_s(4'b0010, 4'b0000, 1'b1, 16'd1);
        push_s(4'b0100, 4'b0000, 1'b1, 16'd2);
        push_s(4'b1000, 4'b0000, 1'b1, 16'd3);
        push_s(4'b0000, 4'b0001, 1'b0, 16'd0);
        push_s(4'b0000, 4'b0010, 1'b0, 16'd0);
        push_s(4'b0000, 4'b0100, 1'b0, 16'd0);
        push_flush(4'b1000);
        push_done();
        issue(1'b0, 16'd1);
        @(posedge clk); #1;
        start = 1'b1; cfg_load_w = 1'b1; cfg_m = 16'd5;
        @(posedge clk); #1;
        start = 1'b0; cfg_load_w = 1'b0; cfg_m = '0;
        drain("job_b");

        // Job C: zero-length with weight load; start during DONE is ignored
        push_wload();
        push_done();
        issue(1'b1, 16'd0);
        repeat (4) begin
            @(posedge clk); #1;
        end
        start = 1'b1; cfg_load_w = 1'b0; cfg_m = 16'd2;
        @(posedge clk); #1;
        start = 1'b0; cfg_m = '0;
        drain("job_c");

        // Job D: reset while t=2 is visible
        push_s(4'b0001, 4'b0000, 1'b1, 16'd0);
        push_s(4'b0011, 4'b0000, 1'b1, 16'd1);
        push_s(4'b0111, 4'b0000, 1'b1, 16'd2);
        issue(1'b0, 16'd3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midjob_reset_outputs", all_outs(), 64'd0);
`ifdef SA_CTRL_PERF_EN
        check("midjob_perf_busy", 64'(perf_busy_cycles), 64'd0);
        check("midjob_perf_jobs", 64'(perf_jobs), 64'd0);
`endif
        drain("job_d");

        // Job E: normal start after reset
        push_s(4'b0001, 4'b0000, 1'b1, 16'd0);
        push_s(4'b0010, 4'b0000, 1'b1, 16'd1);
        push_s(4'b0100, 4'b0000, 1'b1, 16'd2);
        push_s(4'b1000, 4'b0000, 1'b1, 16'd3);
        push_s(4'b0000, 4'b0001, 1'b0, 16'd0);
        push_s(4'b0000, 4'b0010, 1'b0, 16'd0);
        push_s(4'b0000, 4'b0100, 1'b0, 16'd0);
        push_flush(4'b1000);
        push_done();
        issue(1'b0, 16'd1);
        drain("job_e");
        check("final_idle", all_outs(), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule
